bram_seq_ctrl: RTL and testbench

- Sequencer and port owner for the 64 x 64-bit simple dual-port, read-first BRAM used in the Lab5 regfile/SDU datapath.
- On a start pulse it runs a self-test:
  - FILL: writes pattern addr+1 to every address through port A.
  - READ: reads every address back through port B and compares against the pattern.
  - Reports pass/fail.
- When idle, it passes single-beat read/write requests from one external requester (the SDU) to the BRAM.

---
 rtl/bram_seq_pkg.sv | 30 +++
 rtl/bram_rd_pipe.sv | 42 ++++
 rtl/bram_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bram_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_seq_pkg.sv
// Shared types, default widths and the self-test pattern for the BRAM sequencer.
// Optional second inverted pass is enabled by defining BRAM_SEQ_MARCH_EN.
package bram_seq_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RD_LAT = 1;

    // Wide enough for any practical DATA_W; callers size-cast the result down.
    localparam int PAT_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READ,
        DRAIN,
        DONE
    } state_t;

    // addr+1, optionally inverted; truncation to DATA_W equals DATA_W-bit math.
    function automatic logic [PAT_W-1:0] pattern(
        input logic [31:0] addr,
        input logic        inv
    );
        logic [PAT_W-1:0] p;
        p = PAT_W'(addr) + PAT_W'(1);
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-latency delay line carrying {valid, self-test tag, addr} per beat.
// Ports: clk, rstn, i_v/i_tst/i_addr in, o_v/o_tst/o_addr out after LAT cycles.
module bram_rd_pipe #(
    parameter int ADDR_W = 6,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_v,
    input  logic              i_tst,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_v,
    output logic              o_tst,
    output logic [ADDR_W-1:0] o_addr
);

    logic [LAT-1:0]    r_v;
    logic [LAT-1:0]    r_t;
    logic [ADDR_W-1:0] r_a [LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v <= '0;
            r_t <= '0;
            for (int i = 0; i < LAT; i++) r_a[i] <= '0;
        end else begin
            r_v[0] <= i_v;
            r_t[0] <= i_tst;
            r_a[0] <= i_addr;
            for (int i = 1; i < LAT; i++) begin
                r_v[i] <= r_v[i-1];
                r_t[i] <= r_t[i-1];
                r_a[i] <= r_a[i-1];
            end
        end
    end

    assign o_v    = r_v[LAT-1];
    assign o_tst  = r_t[LAT-1];
    assign o_addr = r_a[LAT-1];

endmodule

// File: rtl/bram_seq_ctrl.sv
// BRAM self-test sequencer (fill/read/compare) and idle-time requester port mux.
// Ports: start/busy/done/err* status, BRAM A/B ports, req_*/rsp_* requester.
// Define BRAM_SEQ_MARCH_EN for a second pass with the inverted pattern.
module bram_seq_ctrl
    import bram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W+1:0] err_cnt,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);

    localparam int                DCW     = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [DCW-1:0]    DR_LAST = DCW'(RD_LAT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DCW-1:0]    r_dcnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic [ADDR_W+1:0] r_err_cnt;

    logic              w_inv;
    logic              w_idle;
    logic              w_acc;
    logic              w_rd_acc;
    logic              w_wea;
    logic [ADDR_W-1:0] w_addra;
    logic [ADDR_W-1:0] w_addrb;
    logic [DATA_W-1:0] w_dina;
    logic [DATA_W-1:0] w_pat_wr;
    logic [DATA_W-1:0] w_pat_cmp;
    logic              w_p_v;
    logic              w_p_t;
    logic [ADDR_W-1:0] w_p_addr;
    logic              w_mis;

`ifdef BRAM_SEQ_MARCH_EN
    logic r_pass;
    assign w_inv = r_pass;
`else
    assign w_inv = 1'b0;
`endif

    assign w_idle    = (r_state == IDLE);
    assign req_ready = w_idle & ~start;
    assign w_acc     = req_valid & req_ready;
    assign w_rd_acc  = w_acc & ~req_we;

    assign w_pat_wr  = DATA_W'(pattern(32'(r_cnt), w_inv));
    assign w_pat_cmp = DATA_W'(pattern(32'(w_p_addr), w_inv));

    always_comb begin
        w_wea   = 1'b0;
        w_addra = r_cnt;
        w_addrb = r_cnt;
        w_dina  = w_pat_wr;
        unique case (r_state)
            IDLE: begin
                w_wea   = w_acc & req_we;
                w_addra = req_addr;
                w_addrb = req_addr;
                w_dina  = req_wdata;
            end
            FILL:    w_wea = 1'b1;
            default: w_wea = 1'b0;
        endcase
    end

    // Reset must kill the write strobe without waiting for a clock.
    assign wea   = w_wea & rstn;
    assign addra = w_addra;
    assign addrb = w_addrb;
    assign dina  = w_dina;

    bram_rd_pipe #(
        .ADDR_W (ADDR_W),
        .LAT    (RD_LAT)
    ) u_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .i_v    (w_rd_acc | (r_state == READ)),
        .i_tst  (r_state == READ),
        .i_addr (r_cnt),
        .o_v    (w_p_v),
        .o_tst  (w_p_t),
        .o_addr (w_p_addr)
    );

    // Tagged beats are self-test reads; only untagged ones reach the requester.
    assign rsp_valid = w_p_v & ~w_p_t;
    assign rsp_rdata = doutb;
    assign w_mis     = w_p_v & w_p_t & (doutb != w_pat_cmp);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dcnt     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
`ifdef BRAM_SEQ_MARCH_EN
            r_pass     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_mis) begin
                r_err <= 1'b1;
                if (!r_err) r_err_addr <= w_p_addr;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FILL;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_dcnt     <= '0;
                        r_err      <= 1'b0;
                        r_err_addr <= '0;
                        r_err_cnt  <= '0;
`ifdef BRAM_SEQ_MARCH_EN
                        r_pass     <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= READ;
                end
                READ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (r_dcnt == DR_LAST) begin
                        r_dcnt <= '0;
`ifdef BRAM_SEQ_MARCH_EN
                        if (!r_pass) begin
                            r_pass  <= 1'b1;
                            r_state <= FILL;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign err_addr = r_err_addr;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Self-checking bench for bram_seq_ctrl with a behavioural read-first BRAM.
// Builds with or without BRAM_SEQ_MARCH_EN.
module tb_bram_seq_ctrl;

`ifdef BRAM_SEQ_MARCH_EN
    localparam int RDL     = 2;
    localparam int EXP_LEN = 261;
`else
    localparam int RDL     = 1;
    localparam int EXP_LEN = 130;
`endif

    logic        clk;
    logic        rstn;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  err_addr;
    logic [7:0]  err_cnt;
    logic        wea;
    logic [5:0]  addra;
    logic [63:0] dina;
    logic [5:0]  addrb;
    logic [63:0] doutb;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic        stuck;
    logic [63:0] mem [64];
    logic [63:0] dq  [RDL];
    logic [63:0] rd_val;

    bram_seq_ctrl #(
        .ADDR_W (6),
        .DATA_W (64),
        .RD_LAT (RDL)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .addrb     (addrb),
        .doutb     (doutb),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM; bit 0 of address 17 reads as 1 when stuck is set.
    assign rd_val = mem[addrb] | {63'd0, (stuck && addrb == 6'd17)};
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        dq[0] <= rd_val;
        for (int i = 1; i < RDL; i++) dq[i] <= dq[i-1];
    end
    assign doutb = dq[RDL-1];

    typedef struct packed {
        logic        st;
        logic        v;
        logic        we;
        logic [5:0]  a;
        logic [63:0] wd;
        logic        rdy;
        logic        wea;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_test(output int busy_n, output int done_at,
                            output int rdy_n, output int rsp_n,
                            output logic e, output logic [5:0] ea,
                            output logic [7:0] ec, output logic rdy0,
                            output logic wea0);
        busy_n  = 0;
        done_at = 0;
        rdy_n   = 0;
        rsp_n   = 0;
        e       = 1'bx;
        ea      = 'x;
        ec      = 'x;
        start   = 1'b1;
        #1;
        rdy0 = req_ready;
        wea0 = wea;
        tick();
        for (int n = 1; n <= 600; n++) begin
            start = (n == 10);
            #1;
            if (busy)      busy_n++;
            if (req_ready) rdy_n++;
            if (rsp_valid) rsp_n++;
            if (done) begin
                done_at = n;
                e  = err;
                ea = err_addr;
                ec = err_cnt;
                break;
            end
            tick();
        end
        start = 1'b0;
    endtask

    int          bn, da, rn, sn, cyc;
    logic        e, r0, w0;
    logic [5:0]  ea;
    logic [7:0]  ec;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        stuck     = 1'b0;
        rstn      = 1'b0;
        start     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 6'd0,  64'h0,                  1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 6'd5,  64'hDEAD_BEEF,          1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 6'd9,  64'hAAAA,               1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 6'd3,  64'h55,                 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 6'd0,  64'h0,                  1'b0, 1'b0};

        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rstn = 1'b1;
        tick();

        foreach (tbl[i]) begin
            start     = tbl[i].st;
            req_valid = tbl[i].v;
            req_we    = tbl[i].we;
            req_addr  = tbl[i].a;
            req_wdata = tbl[i].wd;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_wea", i), wea, tbl[i].wea);
            chk($sformatf("vec%0d_addra", i), addra, tbl[i].a);
            chk($sformatf("vec%0d_addrb", i), addrb, tbl[i].a);
            chk($sformatf("vec%0d_dina", i), dina, tbl[i].wd);
            start     = 1'b0;
            req_valid = 1'b0;
            tick();
        end
        chk("idle_busy", busy, 0);

        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("t1_busy_cycles", bn, EXP_LEN - 1);
        chk("t1_done_cycle", da, EXP_LEN);
        chk("t1_err", e, 0);
        chk("t1_err_cnt", ec, 0);
        chk("t1_no_rsp", sn, 0);
        tick();
        chk("t1_done_pulse", done, 0);
`ifdef BRAM_SEQ_MARCH_EN
        chk("t1_mem0", mem[0], ~64'd1);
        chk("t1_mem10", mem[10], ~64'd11);
        chk("t1_mem63", mem[63], ~64'd64);
`else
        chk("t1_mem0", mem[0], 64'd1);
        chk("t1_mem63", mem[63], 64'd64);
`endif

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'd5;
        req_wdata = 64'hDEAD_BEEF;
        tick();
        req_we = 1'b0;
        #1;
        chk("rd_pre_rsp", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("rd_latency", cyc, RDL);
        chk("rd_data", rsp_rdata, 64'hDEAD_BEEF);
        tick();
        chk("rd_rsp_one_beat", rsp_valid, 0);

        stuck = 1'b1;
        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("t2_done_cycle", da, EXP_LEN);
        chk("t2_err", e, 1);
        chk("t2_err_addr", ea, 17);
        chk("t2_err_cnt", ec, 1);
        tick();
        chk("t2_err_sticky", err, 1);

        stuck = 1'b0;
        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("t3_err_cleared", e, 0);
        chk("t3_err_cnt", ec, 0);
        tick();

        stuck = 1'b1;
        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("t4_err", e, 1);
        tick();
        stuck = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("rst_idle_err", err, 0);
        chk("rst_idle_err_addr", err_addr, 0);
        chk("rst_idle_err_cnt", err_cnt, 0);
        tick();
        rstn = 1'b1;
        tick();

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'd7;
        req_wdata = 64'h1234;
        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("col_ready_at_start", r0, 0);
        chk("col_wea_at_start", w0, 0);
        chk("col_ready_in_test", rn, 0);
        chk("col_done_cycle", da, EXP_LEN);
        tick();
        chk("col_idle_ready", req_ready, 1);
        chk("col_idle_wea", wea, 1);
        chk("col_idle_addra", addra, 7);
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        chk("col_mem7", mem[7], 64'h1234);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 40; n++) tick();
        chk("mid_wea_before", wea, 1);
        rstn = 1'b0;
        #1;
        chk("mid_wea", wea, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_err_cnt", err_cnt, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        tick();
        tick();
        rstn = 1'b1;
        cyc = 0;
        for (int n = 0; n < 150; n++) begin
            if (done || busy) cyc++;
            tick();
        end
        chk("mid_no_done", cyc, 0);
        run_test(bn, da, rn, sn, e, ea, ec, r0, w0);
        chk("mid_rerun_busy", bn, EXP_LEN - 1);
        chk("mid_rerun_done", da, EXP_LEN);
        chk("mid_rerun_err", e, 0);
        tick();
`ifdef BRAM_SEQ_MARCH_EN
        chk("mid_rerun_mem63", mem[63], ~64'd64);
`else
        chk("mid_rerun_mem63", mem[63], 64'd64);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
